wave_gen: RTL and testbench

Parametrised multi-mode waveform generator for motor velocity and other actuator set-points. It is the next generation of the fixed 8-bit triangle generator: output width, prescaler width, step size, limits and waveform shape are all programmable. It runs off the system clock and drives a signed set-point bus plus period-marker strobes to downstream motor control logic.

---
 rtl/wave_gen.sv | 155 +++++++++++++++
 tb/tb_wave_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen.sv
// wave_gen: programmable triangle / sawtooth / square / hold set-point generator
// with a run-time prescaler. Emits a registered signed sample plus tick/wrap strobes.
module wave_gen #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic                        cclk,
    input  logic                        rstb,
    input  logic                        clr,
    input  logic                        en,
    input  logic [1:0]                  mode,
    input  logic [DIV_WIDTH-1:0]        div,
    input  logic [WIDTH-2:0]            step,
    input  logic signed [WIDTH-1:0]     lo,
    input  logic signed [WIDTH-1:0]     hi,
    output logic signed [WIDTH-1:0]     wave,
    output logic                        dir,
    output logic                        tick,
    output logic                        wrap
);

    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic [1:0] {
        MODE_TRI  = 2'b00,
        MODE_SAW  = 2'b01,
        MODE_SQR  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
    logic signed [WIDTH-1:0] wave_q, wave_d;
    logic                    dir_q, dir_d;
    logic                    tick_q, tick_d;
    logic                    wrap_q, wrap_d;

    logic signed [XW-1:0]    wave_x, lo_x, hi_x, step_x;
    logic signed [WIDTH-1:0] inc_c, dec_c, lo_c, hi_c;
    mode_e                   mode_s;

    // Clamp a widened value to [lo, hi]; hi bound first, so lo > hi yields lo.
    function automatic logic signed [WIDTH-1:0] clamp(
        input logic signed [XW-1:0] v,
        input logic signed [XW-1:0] lo_v,
        input logic signed [XW-1:0] hi_v
    );
        logic signed [XW-1:0] r;
        r = v;
        if (r > hi_v) r = hi_v;
        if (r < lo_v) r = lo_v;
        return r[WIDTH-1:0];
    endfunction

    // Widened operands and the candidate next samples.
    always_comb begin
        mode_s = mode_e'(mode);
        wave_x = {wave_q[WIDTH-1], wave_q};
        lo_x   = {lo[WIDTH-1], lo};
        hi_x   = {hi[WIDTH-1], hi};
        step_x = {2'b00, step};
        inc_c  = clamp(wave_x + step_x, lo_x, hi_x);
        dec_c  = clamp(wave_x - step_x, lo_x, hi_x);
        lo_c   = clamp(lo_x, lo_x, hi_x);
        hi_c   = clamp(hi_x, lo_x, hi_x);
    end

    // Next-state: prescaler, waveform update rules and strobes.
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            wave_d = '0;
            dir_d  = 1'b1;
        end else if (!en) begin
            cnt_d = '0;
        end else if (cnt_q >= div) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            unique case (mode_s)
                MODE_TRI: begin
                    if (dir_q) begin
                        if (wave_q >= hi) begin
                            dir_d  = 1'b0;
                            wave_d = dec_c;
                        end else begin
                            wave_d = inc_c;
                        end
                    end else begin
                        if (wave_q <= lo) begin
                            dir_d  = 1'b1;
                            wave_d = inc_c;
                            wrap_d = 1'b1;
                        end else begin
                            wave_d = dec_c;
                        end
                    end
                end
                MODE_SAW: begin
                    dir_d = 1'b1;
                    if (wave_q >= hi) begin
                        wave_d = lo_c;
                        wrap_d = 1'b1;
                    end else begin
                        wave_d = inc_c;
                    end
                end
                MODE_SQR: begin
                    if (dir_q) begin
                        wave_d = hi_c;
                        dir_d  = 1'b0;
                        wrap_d = 1'b1;
                    end else begin
                        wave_d = lo_c;
                        dir_d  = 1'b1;
                    end
                end
                MODE_HOLD: begin
                    wave_d = wave_q;
                end
                default: begin
                    wave_d = wave_q;
                end
            endcase
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            cnt_q  <= '0;
            wave_q <= '0;
            dir_q  <= 1'b1;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign wave = wave_q;
    assign dir  = dir_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_wave_gen.sv
// Testbench for wave_gen: directed scenarios plus randomized stimulus against a reference model.
module tb_wave_gen;

    logic              cclk;
    logic              rstb;
    logic              clr;
    logic              en;
    logic [1:0]        mode;
    logic [23:0]       div;
    logic [6:0]        step;
    logic signed [7:0] lo;
    logic signed [7:0] hi;
    logic signed [7:0] wave;
    logic              dir;
    logic              tick;
    logic              wrap;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_wave = 0;
    int m_dir  = 1;
    int m_cnt  = 0;
    int m_tick = 0;
    int m_wrap = 0;

    wave_gen #(.WIDTH(8), .DIV_WIDTH(24)) dut (
        .cclk (cclk),
        .rstb (rstb),
        .clr  (clr),
        .en   (en),
        .mode (mode),
        .div  (div),
        .step (step),
        .lo   (lo),
        .hi   (hi),
        .wave (wave),
        .dir  (dir),
        .tick (tick),
        .wrap (wrap)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lim(input int v);
        int r;
        r = v;
        if (r > int'(hi)) r = int'(hi);
        if (r < int'(lo)) r = int'(lo);
        return r;
    endfunction

    task automatic model_reset();
        m_wave = 0; m_dir = 1; m_cnt = 0; m_tick = 0; m_wrap = 0;
    endtask

    // One rising edge of the behavioural model, using the inputs held since the last falling edge.
    task automatic model_edge();
        int s;
        s = int'(step);
        if (!rstb || clr) begin
            model_reset();
        end else if (!en) begin
            m_cnt = 0; m_tick = 0; m_wrap = 0;
        end else if (m_cnt >= int'(div)) begin
            m_cnt = 0; m_tick = 1; m_wrap = 0;
            case (mode)
                2'b00: begin
                    if (m_dir == 1 && m_wave >= int'(hi)) begin
                        m_dir = 0; m_wave = lim(m_wave - s);
                    end else if (m_dir == 1) begin
                        m_wave = lim(m_wave + s);
                    end else if (m_wave <= int'(lo)) begin
                        m_dir = 1; m_wave = lim(m_wave + s); m_wrap = 1;
                    end else begin
                        m_wave = lim(m_wave - s);
                    end
                end
                2'b01: begin
                    m_dir = 1;
                    if (m_wave >= int'(hi)) begin
                        m_wave = lim(int'(lo)); m_wrap = 1;
                    end else begin
                        m_wave = lim(m_wave + s);
                    end
                end
                2'b10: begin
                    if (m_dir == 1) begin
                        m_wave = lim(int'(hi)); m_dir = 0; m_wrap = 1;
                    end else begin
                        m_wave = lim(int'(lo)); m_dir = 1;
                    end
                end
                default: ;
            endcase
        end else begin
            m_cnt++; m_tick = 0; m_wrap = 0;
        end
    endtask

    task automatic compare_all();
        check("wave", int'(wave), m_wave);
        check("dir",  int'(dir),  m_dir);
        check("tick", int'(tick), m_tick);
        check("wrap", int'(wrap), m_wrap);
    endtask

    task automatic cycle();
        @(posedge cclk);
        model_edge();
        @(negedge cclk);
        compare_all();
    endtask

    task automatic clear_once();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    int n_tick;
    int n_wrap;

    initial begin
        clr = 0; en = 0; mode = 2'b00; div = 24'd3; step = 7'd1; lo = -8'sd128; hi = 8'sd127;
        rstb = 1'b1;
        #1 rstb = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge cclk);
        rstb = 1'b1;
        cycle();

        // Triangle full period, div=3, step=1, full-scale limits
        en = 1'b1;
        n_tick = 0; n_wrap = 0;
        for (int i = 0; i < 510 * 4; i++) begin
            cycle();
            n_tick += int'(tick);
            n_wrap += int'(wrap);
        end
        check("tri_ticks", n_tick, 510);
        check("tri_wraps", n_wrap, 1);
        check("tri_end_wave", int'(wave), 0);
        check("tri_end_dir", int'(dir), 1);

        // Sawtooth every cycle
        clear_once();
        mode = 2'b01; div = 24'd0; step = 7'd50; lo = -8'sd100; hi = 8'sd100;
        n_wrap = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_wrap += int'(wrap);
        end
        check("saw_wraps", n_wrap, 2);

        // Square, div=1
        mode = 2'b10; div = 24'd1; lo = -8'sd20; hi = 8'sd20;
        for (int i = 0; i < 12; i++) cycle();

        // Triangle heading up, then hi pulled below the current sample
        clear_once();
        mode = 2'b00; div = 24'd0; step = 7'd25; lo = -8'sd128; hi = 8'sd127;
        for (int i = 0; i < 4; i++) cycle();
        check("pre_hi_wave", int'(wave), 100);
        hi = 8'sd10;
        cycle();
        check("hi_drop_wave", int'(wave), 10);
        check("hi_drop_dir", int'(dir), 0);

        // Crossed limits: every update loads lo
        lo = 8'sd5; hi = -8'sd5; div = 24'd2;
        for (int i = 0; i < 12; i++) cycle();
        check("bad_lim_wave", int'(wave), 5);

        // en dropped mid-count then restored
        lo = -8'sd50; hi = 8'sd50; step = 7'd3; div = 24'd4;
        for (int i = 0; i < 8; i++) cycle();
        en = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        en = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        // Hold mode with a long divide
        mode = 2'b11; div = 24'd200;
        n_tick = 0; n_wrap = 0;
        for (int i = 0; i < 1005; i++) begin
            cycle();
            n_tick += int'(tick);
            n_wrap += int'(wrap);
        end
        check("hold_wraps", n_wrap, 0);
        check("hold_ticks_min", int'(n_tick >= 4), 1);

        // Randomized stimulus
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63) == 0) clr = 1'b1; else clr = 1'b0;
            en = ($urandom_range(15) != 0);
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) div = 24'($urandom_range(5));
            if ($urandom_range(7) == 0) step = 7'($urandom_range(127));
            if ($urandom_range(31) == 0) lo = 8'($urandom_range(255));
            if ($urandom_range(31) == 0) hi = 8'($urandom_range(255));
            cycle();
        end
        clr = 1'b0;

        // Asynchronous reset between edges
        mode = 2'b00; div = 24'd0; step = 7'd7; lo = -8'sd100; hi = 8'sd100; en = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        clr = 1'b1;
        #2 rstb = 1'b0;
        #1;
        model_reset();
        check("arst_wave", int'(wave), 0);
        check("arst_dir",  int'(dir),  1);
        check("arst_tick", int'(tick), 0);
        check("arst_wrap", int'(wrap), 0);
        @(negedge cclk);
        rstb = 1'b1;
        clr  = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
